imem_cache_responder: RTL and testbench

- Responder side of the instruction-memory handshake: services `imem_read`/`imem_address` from the fetch unit and returns `imem_rdata`/`imem_resp`.
- Direct-mapped, read-only instruction cache with single-line fills from a 128-bit physical-memory read port.
- Sits between the fetch unit and the pmem arbiter.
- Also exports saturating hit and miss counters for performance measurement.

---
 rtl/imem_cache_responder_if.sv | 23 ++
 rtl/imem_cache_responder.sv | 117 +++++++++++
 tb/tb_imem_cache_responder.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/imem_cache_responder_if.sv
// Instruction-fetch and line-fill handshake bundle for the instruction cache.
// The slave modport is the cache; the master modport is the environment that
// combines the fetch unit and the pmem arbiter.
interface imem_cache_responder_if;
   logic         imem_read;
   logic [15:0]  imem_address;
   logic [15:0]  imem_rdata;
   logic         imem_resp;
   logic         pmem_read;
   logic [15:0]  pmem_address;
   logic [127:0] pmem_rdata;
   logic         pmem_resp;

   modport slave (
      input  imem_read, imem_address, pmem_rdata, pmem_resp,
      output imem_rdata, imem_resp, pmem_read, pmem_address
   );

   modport master (
      output imem_read, imem_address, pmem_rdata, pmem_resp,
      input  imem_rdata, imem_resp, pmem_read, pmem_address
   );
endinterface

// File: rtl/imem_cache_responder.sv
// Direct-mapped, read-only instruction cache. Hits answer in the same cycle;
// misses fetch one 128-bit line from pmem, install it, and re-look-up.
// Saturating hit/miss counters are exported for performance measurement.
module imem_cache_responder #(
   parameter int  INDEX_BITS = 3,
   localparam int TAG_BITS   = 12 - INDEX_BITS,
   localparam int LINES      = 1 << INDEX_BITS
) (
   input  logic                  clk,
   input  logic                  reset_n,
   imem_cache_responder_if.slave bus,
   output logic [15:0]           hit_count,
   output logic [15:0]           miss_count
);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t                state_q, state_d;
   logic [LINES-1:0]      valid_q;
   logic [TAG_BITS-1:0]   tag_q  [LINES];
   logic [127:0]          data_q [LINES];
   logic [15:0]           fill_addr_q, fill_addr_d;
   logic [15:0]           hit_count_q, hit_count_d;
   logic [15:0]           miss_count_q, miss_count_d;
   logic                  install;

   // Address fields of the live request and of the latched fill.
   logic [2:0]            req_offset;
   logic [INDEX_BITS-1:0] req_index, fill_index;
   logic [TAG_BITS-1:0]   req_tag, fill_tag;
   logic                  req_valid, hit;
   logic [127:0]          req_line;
   logic                  unused_addr_bit;

   assign req_offset      = bus.imem_address[3:1];
   assign req_index       = bus.imem_address[3+INDEX_BITS:4];
   assign req_tag         = bus.imem_address[15:4+INDEX_BITS];
   assign fill_index      = fill_addr_q[3+INDEX_BITS:4];
   assign fill_tag        = fill_addr_q[15:4+INDEX_BITS];
   assign unused_addr_bit = bus.imem_address[0];

   assign req_valid = valid_q[req_index];
   assign req_line  = data_q[req_index];
   // The valid bit masks the tag compare, so an uninstalled line never hits
   // even though its tag register holds garbage.
   assign hit       = bus.imem_read & req_valid & (tag_q[req_index] == req_tag);

   // Invalid lines read as zero so never-written storage cannot leak X.
   assign bus.imem_rdata   = req_valid ? req_line[{req_offset, 4'b0000} +: 16] : 16'h0000;
   assign bus.pmem_address = fill_addr_q;
   assign hit_count        = hit_count_q;
   assign miss_count       = miss_count_q;

   // Next-state, response and counter logic.
   always_comb begin
      // NOTE: every output of this block gets a default first so that no path
      // leaves a signal unassigned, which would otherwise infer a latch.
      state_d       = state_q;
      fill_addr_d   = fill_addr_q;
      hit_count_d   = hit_count_q;
      miss_count_d  = miss_count_q;
      install       = 1'b0;
      bus.imem_resp = 1'b0;
      bus.pmem_read = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               bus.imem_resp = 1'b1;
               if (hit_count_q != 16'hFFFF) hit_count_d = hit_count_q + 16'd1;
            end else if (bus.imem_read) begin
               fill_addr_d = {req_tag, req_index, 4'b0000};
               if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
               state_d = S_FILL;
            end
         end
         S_FILL: begin
            // The fill finishes regardless of what the fetch side does now.
            bus.pmem_read = 1'b1;
            if (bus.pmem_resp) begin
               install = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state, counters and valid bits; reset drops pmem_read at once.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (!reset_n) begin
         state_q      <= S_IDLE;
         fill_addr_q  <= 16'h0000;
         hit_count_q  <= 16'h0000;
         miss_count_q <= 16'h0000;
         valid_q      <= '0;
      end else begin
         state_q      <= state_d;
         fill_addr_q  <= fill_addr_d;
         hit_count_q  <= hit_count_d;
         miss_count_q <= miss_count_d;
         if (install) valid_q[fill_index] <= 1'b1;
      end
   end

   // Line storage: tag and data written on fill completion.
   // NOTE: tag/data arrays have no reset; the valid bits alone decide whether
   // a line is usable, and leaving the arrays unreset lets them map to RAM.
   always_ff @(posedge clk) begin
      if (install) begin
         tag_q[fill_index]  <= fill_tag;
         data_q[fill_index] <= bus.pmem_rdata;
      end
   end

endmodule

// File: tb/tb_imem_cache_responder.sv
// Directed bench for imem_cache_responder: miss latency, line hits, conflict,
// abandoned fill, reset during fill, and hit counter saturation.
module tb_imem_cache_responder;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [15:0] hit_count, miss_count;
   int          vectors = 0;
   int          miscompares = 0;

   logic [127:0] line_a, line_b, line_c, line_d;

   always #5 clk = ~clk;

   imem_cache_responder_if bus ();

   imem_cache_responder #(.INDEX_BITS(3)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   // Inputs change right after the falling edge; sampling is done #1 later.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive_idle();
      bus.imem_read    = 1'b0;
      bus.imem_address = 16'h0000;
      bus.pmem_resp    = 1'b0;
      bus.pmem_rdata   = '0;
   endtask

   task automatic test_reset();
      drive_idle();
      reset_n = 1'b0;
      repeat (2) step();
      #1;
      vectors++; if (bus.pmem_read !== 1'b0) begin miscompares++; $display("FAIL reset_pmem_read got=%b exp=0", bus.pmem_read); end
      vectors++; if (bus.imem_resp !== 1'b0) begin miscompares++; $display("FAIL reset_imem_resp got=%b exp=0", bus.imem_resp); end
      vectors++; if (bus.pmem_address !== 16'h0000) begin miscompares++; $display("FAIL reset_pmem_address got=%h exp=0000", bus.pmem_address); end
      vectors++; if (hit_count !== 16'h0000) begin miscompares++; $display("FAIL reset_hit_count got=%h exp=0000", hit_count); end
      vectors++; if (miss_count !== 16'h0000) begin miscompares++; $display("FAIL reset_miss_count got=%h exp=0000", miss_count); end
      reset_n = 1'b1;
      step();
   endtask

   // Request 0x1234, answer the fill on the third FILL cycle (N=3): resp in cycle 5.
   task automatic test_miss_latency();
      int          lat;
      logic [15:0] got;
      lat = 0;
      got = 16'h0000;
      bus.imem_read    = 1'b1;
      bus.imem_address = 16'h1234;
      for (int k = 0; k < 12; k++) begin
         bus.pmem_resp  = (k == 3);
         bus.pmem_rdata = (k == 3) ? line_a : '0;
         #1;
         if (k == 1) begin
            vectors++; if (bus.pmem_read !== 1'b1) begin miscompares++; $display("FAIL miss_pmem_read got=%b exp=1", bus.pmem_read); end
            vectors++; if (bus.pmem_address !== 16'h1230) begin miscompares++; $display("FAIL miss_pmem_address got=%h exp=1230", bus.pmem_address); end
            vectors++; if (miss_count !== 16'h0001) begin miscompares++; $display("FAIL miss_count_first got=%h exp=0001", miss_count); end
         end
         if (bus.imem_resp === 1'b1 && lat == 0) begin
            lat = k + 1;
            got = bus.imem_rdata;
         end
         step();
         if (lat != 0) break;
      end
      bus.pmem_resp = 1'b0;
      vectors++; if (lat != 5) begin miscompares++; $display("FAIL miss_latency got=%0d exp=5", lat); end
      vectors++; if (got !== 16'hBEEF) begin miscompares++; $display("FAIL miss_rdata got=%h exp=beef", got); end
      vectors++; if (hit_count !== 16'h0001) begin miscompares++; $display("FAIL miss_hit_count got=%h exp=0001", hit_count); end
   endtask

   // Walk all eight words of the resident line on consecutive cycles.
   task automatic test_sequential_hits();
      logic [15:0] exp_word;
      for (int w = 0; w < 8; w++) begin
         bus.imem_address = 16'h1230 + 16'(2 * w);
         exp_word = line_a[16*w +: 16];
         #1;
         vectors++; if (bus.imem_resp !== 1'b1) begin miscompares++; $display("FAIL seq_resp w=%0d got=%b exp=1", w, bus.imem_resp); end
         vectors++; if (bus.imem_rdata !== exp_word) begin miscompares++; $display("FAIL seq_rdata w=%0d got=%h exp=%h", w, bus.imem_rdata, exp_word); end
         vectors++; if (bus.pmem_read !== 1'b0) begin miscompares++; $display("FAIL seq_pmem_read w=%0d got=%b exp=0", w, bus.pmem_read); end
         step();
      end
      vectors++; if (hit_count !== 16'd9) begin miscompares++; $display("FAIL seq_hit_count got=%0d exp=9", hit_count); end
      vectors++; if (miss_count !== 16'd1) begin miscompares++; $display("FAIL seq_miss_count got=%0d exp=1", miss_count); end
   endtask

   // 0x1A34 shares index 3 with 0x1234 but has a different tag.
   task automatic test_conflict();
      bus.imem_address = 16'h1A34;
      #1;
      vectors++; if (bus.imem_resp !== 1'b0) begin miscompares++; $display("FAIL conf_first_resp got=%b exp=0", bus.imem_resp); end
      step();
      #1;
      vectors++; if (bus.pmem_read !== 1'b1) begin miscompares++; $display("FAIL conf_pmem_read got=%b exp=1", bus.pmem_read); end
      vectors++; if (bus.pmem_address !== 16'h1A30) begin miscompares++; $display("FAIL conf_pmem_address got=%h exp=1a30", bus.pmem_address); end
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = line_b;
      step();
      bus.pmem_resp = 1'b0;
      #1;
      vectors++; if (bus.imem_resp !== 1'b1) begin miscompares++; $display("FAIL conf_hit_resp got=%b exp=1", bus.imem_resp); end
      vectors++; if (bus.imem_rdata !== line_b[47:32]) begin miscompares++; $display("FAIL conf_hit_rdata got=%h exp=%h", bus.imem_rdata, line_b[47:32]); end
      step();
      bus.imem_address = 16'h1234;
      #1;
      vectors++; if (bus.imem_resp !== 1'b0) begin miscompares++; $display("FAIL conf_evicted_resp got=%b exp=0", bus.imem_resp); end
      step();
      #1;
      vectors++; if (bus.pmem_address !== 16'h1230) begin miscompares++; $display("FAIL conf_refill_address got=%h exp=1230", bus.pmem_address); end
      vectors++; if (miss_count !== 16'd3) begin miscompares++; $display("FAIL conf_miss_count got=%0d exp=3", miss_count); end
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = line_a;
      step();
      bus.pmem_resp = 1'b0;
      #1;
      vectors++; if (bus.imem_rdata !== 16'hBEEF || bus.imem_resp !== 1'b1) begin miscompares++; $display("FAIL conf_refill_hit got=%b/%h exp=1/beef", bus.imem_resp, bus.imem_rdata); end
      step();
      vectors++; if (hit_count !== 16'd11) begin miscompares++; $display("FAIL conf_hit_count got=%0d exp=11", hit_count); end
   endtask

   // Fill for 0x0040 completes after the fetch side gives up; 0x0042 then hits.
   task automatic test_fill_abandon();
      bus.imem_address = 16'h0040;
      step();
      bus.imem_read    = 1'b0;
      bus.imem_address = 16'h0000;
      #1;
      vectors++; if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h0040) begin miscompares++; $display("FAIL abandon_fill got=%b/%h exp=1/0040", bus.pmem_read, bus.pmem_address); end
      step();
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = line_c;
      #1;
      vectors++; if (bus.imem_resp !== 1'b0) begin miscompares++; $display("FAIL abandon_resp_fill got=%b exp=0", bus.imem_resp); end
      step();
      bus.pmem_resp = 1'b0;
      #1;
      vectors++; if (bus.imem_resp !== 1'b0 || bus.pmem_read !== 1'b0) begin miscompares++; $display("FAIL abandon_idle got=%b/%b exp=0/0", bus.imem_resp, bus.pmem_read); end
      bus.imem_read    = 1'b1;
      bus.imem_address = 16'h0042;
      #1;
      vectors++; if (bus.imem_resp !== 1'b1) begin miscompares++; $display("FAIL abandon_rehit_resp got=%b exp=1", bus.imem_resp); end
      vectors++; if (bus.imem_rdata !== line_c[31:16]) begin miscompares++; $display("FAIL abandon_rehit_rdata got=%h exp=%h", bus.imem_rdata, line_c[31:16]); end
      step();
      vectors++; if (bus.pmem_read !== 1'b0) begin miscompares++; $display("FAIL abandon_pmem_read got=%b exp=0", bus.pmem_read); end
      vectors++; if (miss_count !== 16'd4 || hit_count !== 16'd12) begin miscompares++; $display("FAIL abandon_counts got=%0d/%0d exp=12/4", hit_count, miss_count); end
   endtask

   // Reset during FILL kills the fill; a stray pmem_resp in IDLE installs nothing.
   task automatic test_reset_mid_fill();
      bus.imem_address = 16'h0100;
      step();
      #1;
      vectors++; if (bus.pmem_read !== 1'b1) begin miscompares++; $display("FAIL rmf_fill_entered got=%b exp=1", bus.pmem_read); end
      #1;
      reset_n = 1'b0;
      bus.imem_read = 1'b0;
      #1;
      vectors++; if (bus.pmem_read !== 1'b0) begin miscompares++; $display("FAIL rmf_pmem_read_drop got=%b exp=0", bus.pmem_read); end
      vectors++; if (hit_count !== 16'd0 || miss_count !== 16'd0) begin miscompares++; $display("FAIL rmf_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
      step();
      reset_n        = 1'b1;
      bus.pmem_resp  = 1'b1;
      bus.pmem_rdata = line_d;
      #1;
      vectors++; if (bus.imem_resp !== 1'b0) begin miscompares++; $display("FAIL rmf_stray_resp got=%b exp=0", bus.imem_resp); end
      step();
      bus.pmem_resp    = 1'b0;
      bus.imem_read    = 1'b1;
      bus.imem_address = 16'h0000;
      #1;
      vectors++; if (bus.imem_resp !== 1'b0) begin miscompares++; $display("FAIL rmf_stray_installed got=%b exp=0", bus.imem_resp); end
      step();
      bus.pmem_resp = 1'b1;
      step();
      bus.pmem_resp    = 1'b0;
      bus.imem_address = 16'h0100;
      #1;
      vectors++; if (bus.imem_resp !== 1'b0) begin miscompares++; $display("FAIL rmf_partial_installed got=%b exp=0", bus.imem_resp); end
      step();
      #1;
      vectors++; if (bus.pmem_read !== 1'b1 || miss_count !== 16'd2) begin miscompares++; $display("FAIL rmf_refetch got=%b/%0d exp=1/2", bus.pmem_read, miss_count); end
      bus.pmem_resp = 1'b1;
      step();
      bus.pmem_resp = 1'b0;
      #1;
      vectors++; if (bus.imem_resp !== 1'b1 || bus.imem_rdata !== line_d[15:0]) begin miscompares++; $display("FAIL rmf_final_hit got=%b/%h exp=1/%h", bus.imem_resp, bus.imem_rdata, line_d[15:0]); end
   endtask

   // Hold a resident address for more than 65536 cycles.
   task automatic test_hit_saturation();
      repeat (65540) step();
      #1;
      vectors++; if (hit_count !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hit_count got=%h exp=ffff", hit_count); end
      vectors++; if (bus.imem_resp !== 1'b1) begin miscompares++; $display("FAIL sat_resp got=%b exp=1", bus.imem_resp); end
      vectors++; if (miss_count !== 16'd2) begin miscompares++; $display("FAIL sat_miss_count got=%0d exp=2", miss_count); end
   endtask

   initial begin
      line_a = {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
      line_b = {16'hB007, 16'hB006, 16'hB005, 16'hB004, 16'hB003, 16'hB002, 16'hB001, 16'hB000};
      line_c = {16'hC007, 16'hC006, 16'hC005, 16'hC004, 16'hC003, 16'hC002, 16'hC001, 16'hC000};
      line_d = {16'hD007, 16'hD006, 16'hD005, 16'hD004, 16'hD003, 16'hD002, 16'hD001, 16'hD000};
      drive_idle();
      test_reset();
      test_miss_latency();
      test_sequential_hits();
      test_conflict();
      test_fill_abandon();
      test_reset_mid_fill();
      test_hit_saturation();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
